// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit path. It holds
//            the frame state encoding, the frame geometry, the default bit
//            time and the parity helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Frame sequencing states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int FRAME_BITS           = 11;  // start + 8 data + parity + stop
  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 27;  // ~115200 baud at 3.125 MHz

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Bit-time counter. Counts 0..CLKS_PER_BIT-1 and wraps, so the
//            bit timing restarts exactly at every frame and never drifts.
// Ports    : clk       in  1  clock
//            rst       in  1  synchronous active-high reset
//            clear     in  1  hold the counter at zero
//            bit_tick  out 1  high on the last clock of each bit
//            pre_tick  out 1  high on the clock before the last clock of a bit
// Revision : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_tick = (r_cnt == CNT_LAST);
  // Lets the parent register a pulse that lands on the last clock of a bit
  assign pre_tick = (r_cnt == CNT_PRE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : UART transmitter. Sends start(0), 8 data bits MSB first, a
//            parity bit and stop(1); every bit lasts CLKS_PER_BIT clocks.
//            Bytes arrive through a ready/valid handshake.
// Config   : UART_TX_HOLD_BUF_EN - when defined, a one-byte holding register
//            lets the host hand over the next byte while a frame is in flight,
//            and that byte follows the stop bit with no idle gap.
// Ports    : clk_3125  in  1  3.125 MHz system clock
//            rst       in  1  synchronous active-high reset
//            tx_valid  in  1  host offers tx_data
//            tx_data   in  8  byte to send, bit 7 first
//            tx_ready  out 1  byte accepted when tx_valid && tx_ready
//            tx        out 1  serial line, idle high
//            tx_busy   out 1  frame in progress
//            tx_done   out 1  pulse on the last clock of the stop bit
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_3125,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic PARITY_IS_ODD = (PARITY_ODD != 0);

  state_t                r_state;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parity;
  logic [2:0]            r_bit_cnt;
  logic                  r_hold_full;
  logic [DATA_BITS-1:0]  r_hold_data;

  logic                  w_accept;
  logic                  w_bit_tick;
  logic                  w_pre_tick;
  logic                  w_frame_end;
  logic                  w_start_point;
  logic                  w_start_frame;
  logic [DATA_BITS-1:0]  w_start_byte;

  assign w_accept = tx_valid && tx_ready;

  // Counter is parked at zero while idle so every frame starts on a fresh
  // bit boundary; between contiguous frames it simply wraps.
  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk_3125),
    .rst      (rst),
    .clear    (r_state == IDLE),
    .bit_tick (w_bit_tick),
    .pre_tick (w_pre_tick)
  );

  assign w_frame_end   = (r_state == STOP) && w_bit_tick;
  // A new frame may begin from IDLE or directly after the last stop clock
  assign w_start_point = (r_state == IDLE) || w_frame_end;
  assign w_start_frame = w_start_point && (r_hold_full || w_accept);
  // A buffered byte is older than anything offered this cycle, so it goes first
  assign w_start_byte  = r_hold_full ? r_hold_data : tx_data;

`ifdef UART_TX_HOLD_BUF_EN
  assign tx_ready = ~r_hold_full;

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_start_point && r_hold_full) begin
      // Draining: a byte accepted on this same edge takes the freed slot
      r_hold_full <= w_accept;
      if (w_accept) begin
        r_hold_data <= tx_data;
      end
    end else if (w_accept && !w_start_point) begin
      r_hold_full <= 1'b1;
      r_hold_data <= tx_data;
    end
  end
`else
  assign tx_ready    = (r_state == IDLE);
  assign r_hold_full = 1'b0;
  assign r_hold_data = '0;
`endif

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      // Registered one clock ahead so the pulse covers the last stop clock
      tx_done <= (r_state == STOP) && w_pre_tick;

      if (w_start_frame) begin
        r_state   <= START;
        r_shift   <= w_start_byte;
        r_parity  <= calc_parity(w_start_byte, PARITY_IS_ODD);
        r_bit_cnt <= 3'(DATA_BITS - 1);
        tx        <= 1'b0;
        tx_busy   <= 1'b1;
      end else if (w_frame_end) begin
        r_state <= IDLE;
        tx      <= 1'b1;
        tx_busy <= 1'b0;
      end else if (w_bit_tick) begin
        case (r_state)
          START: begin
            r_state <= DATA;
            tx      <= r_shift[DATA_BITS-1];
            r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
          end
          DATA: begin
            if (r_bit_cnt == 3'd0) begin
              r_state <= PARITY;
              tx      <= r_parity;
            end else begin
              r_bit_cnt <= r_bit_cnt - 3'd1;
              tx        <= r_shift[DATA_BITS-1];
              r_shift   <= {r_shift[DATA_BITS-2:0], 1'b0};
            end
          end
          PARITY: begin
            r_state <= STOP;
            tx      <= 1'b1;
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame. A main instance uses the
//            default bit time with even parity; a second instance uses a
//            4-clock bit time with odd parity. Expected line levels come from
//            a frame-level model of the serial format.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_frame;

  localparam int CPB     = 27;
  localparam int FRAME   = 11 * CPB;
  localparam int CPB_O   = 4;
  localparam int FRAME_O = 11 * CPB_O;

  logic       clk_3125 = 1'b0;
  logic       rst      = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;

  logic tx_ready, tx, tx_busy, tx_done;
  logic ready_o, tx_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk_3125 (clk_3125), .rst (rst), .tx_valid (tx_valid), .tx_data (tx_data),
    .tx_ready (tx_ready), .tx (tx), .tx_busy (tx_busy), .tx_done (tx_done)
  );

  uart_tx_frame #(.CLKS_PER_BIT(CPB_O), .PARITY_ODD(1)) dut_odd (
    .clk_3125 (clk_3125), .rst (rst), .tx_valid (tx_valid), .tx_data (tx_data),
    .tx_ready (ready_o), .tx (tx_o), .tx_busy (busy_o), .tx_done (done_o)
  );

  always #5 clk_3125 = ~clk_3125;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Line level k clocks into a frame: bit index 0 start, 1..8 data MSB
  // first, 9 parity, 10 stop.
  function automatic logic exp_bit(input logic [7:0] d, input int k,
                                   input int cpb, input bit odd);
    int idx;
    idx = k / cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[8 - idx];
    if (idx == 9) return odd ? ~^d : ^d;
    return 1'b1;
  endfunction

  // Step to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk_3125);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1)
      begin errors++; $display("FAIL reset_state got tx=%b busy=%b done=%b ready=%b exp 1 0 0 1", tx, tx_busy, tx_done, tx_ready); end
    checks++;
    if (tx_o !== 1'b1 || ready_o !== 1'b1)
      begin errors++; $display("FAIL reset_state_odd got tx=%b ready=%b exp 1 1", tx_o, ready_o); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0)
        begin errors++; $display("FAIL idle_after_reset got tx=%b busy=%b done=%b exp 1 0 0", tx, tx_busy, tx_done); end
    end
  endtask

  task automatic test_known_bytes();
    logic [7:0]  vals [2];
    logic [0:10] a_seq;
    logic [7:0]  b;
    logic        e;
    vals[0] = 8'h41;
    vals[1] = 8'h07;
    a_seq   = 11'b00100000101;
    for (int v = 0; v < 2; v++) begin
      b = vals[v];
      checks++;
      if (tx_ready !== 1'b1 || ready_o !== 1'b1)
        begin errors++; $display("FAIL known_ready got %b/%b exp 1/1", tx_ready, ready_o); end
      tx_valid = 1'b1; tx_data = b;
      tick();
      tx_valid = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        tx_data = 8'($urandom);
        e = exp_bit(b, k, CPB, 1'b0);
        checks++;
        if (tx !== e) begin errors++; $display("FAIL known_tx byte=%h k=%0d got %b exp %b", b, k, tx, e); end
        if (v == 0) begin
          checks++;
          if (tx !== a_seq[k / CPB]) begin errors++; $display("FAIL letter_A_seq k=%0d got %b exp %b", k, tx, a_seq[k / CPB]); end
        end
        checks++;
        if (tx_busy !== 1'b1 || tx_done !== (k == FRAME - 1))
          begin errors++; $display("FAIL known_busy_done k=%0d got busy=%b done=%b exp 1 %b", k, tx_busy, tx_done, (k == FRAME - 1)); end
        if (k < FRAME_O) begin
          e = exp_bit(b, k, CPB_O, 1'b1);
          checks++;
          if (tx_o !== e || done_o !== (k == FRAME_O - 1))
            begin errors++; $display("FAIL odd_parity_frame byte=%h k=%0d got tx=%b done=%b exp %b %b", b, k, tx_o, done_o, e, (k == FRAME_O - 1)); end
        end
        tick();
      end
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1)
        begin errors++; $display("FAIL known_end got tx=%b busy=%b done=%b ready=%b exp 1 0 0 1", tx, tx_busy, tx_done, tx_ready); end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    logic       e;
    int         dones;
    for (int n = 0; n < 6; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      b = 8'($urandom);
      tx_valid = 1'b1; tx_data = b;
      tick();
      tx_valid = 1'b0;
      dones = 0;
      for (int k = 0; k < FRAME; k++) begin
        tx_data = 8'($urandom);
        e = exp_bit(b, k, CPB, 1'b0);
        checks++;
        if (tx !== e) begin errors++; $display("FAIL random_tx byte=%h k=%0d got %b exp %b", b, k, tx, e); end
        if (tx_done === 1'b1) dones++;
        tick();
      end
      checks++;
      if (dones != 1 || tx_busy !== 1'b0)
        begin errors++; $display("FAIL random_done_count byte=%h got %0d busy=%b exp 1 0", b, dones, tx_busy); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic       e;
    b = 8'($urandom);
    tx_valid = 1'b1; tx_data = b;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 150; k++) begin
      e = exp_bit(b, k, CPB, 1'b0);
      checks++;
      if (tx !== e) begin errors++; $display("FAIL pre_reset_tx k=%0d got %b exp %b", k, tx, e); end
      if (k == 149) rst = 1'b1;
      tick();
    end
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1)
      begin errors++; $display("FAIL mid_reset got tx=%b busy=%b done=%b ready=%b exp 1 0 0 1", tx, tx_busy, tx_done, tx_ready); end
    rst = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0)
        begin errors++; $display("FAIL abandoned_frame k=%0d got tx=%b busy=%b done=%b exp 1 0 0", k, tx, tx_busy, tx_done); end
      tick();
    end
    b = 8'($urandom);
    tx_valid = 1'b1; tx_data = b;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      e = exp_bit(b, k, CPB, 1'b0);
      checks++;
      if (tx !== e || tx_done !== (k == FRAME - 1))
        begin errors++; $display("FAIL post_reset_frame k=%0d got tx=%b done=%b exp %b %b", k, tx, tx_done, e, (k == FRAME - 1)); end
      tick();
    end
  endtask

`ifdef UART_TX_HOLD_BUF_EN
  task automatic test_hold_buffer();
    logic [7:0] b0, b1;
    logic       e;
    logic       er;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    tx_valid = 1'b1; tx_data = b0;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      e  = (k < FRAME) ? exp_bit(b0, k, CPB, 1'b0) : exp_bit(b1, k - FRAME, CPB, 1'b0);
      er = (k < 10) || (k >= FRAME);
      checks++;
      if (tx !== e) begin errors++; $display("FAIL hold_tx k=%0d got %b exp %b", k, tx, e); end
      checks++;
      if (tx_busy !== 1'b1 || tx_ready !== er || tx_done !== (k == FRAME - 1 || k == 2 * FRAME - 1))
        begin errors++; $display("FAIL hold_flags k=%0d got busy=%b ready=%b done=%b exp 1 %b %b", k, tx_busy, tx_ready, tx_done, er, (k == FRAME - 1 || k == 2 * FRAME - 1)); end
      if (k == 9) begin tx_valid = 1'b1; tx_data = b1; end
      else if (k == 10) tx_valid = 1'b0;
      else if (k > 10) tx_data = 8'($urandom);
      tick();
    end
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
      begin errors++; $display("FAIL hold_end got tx=%b busy=%b ready=%b exp 1 0 1", tx, tx_busy, tx_ready); end
  endtask
`else
  task automatic test_ignore_midframe();
    logic [7:0] b;
    logic       e;
    b = 8'($urandom);
    tx_valid = 1'b1; tx_data = b;
    tick();
    for (int k = 0; k < FRAME; k++) begin
      tx_data = 8'($urandom);
      e = exp_bit(b, k, CPB, 1'b0);
      checks++;
      if (tx !== e || tx_ready !== 1'b0)
        begin errors++; $display("FAIL ignore_midframe k=%0d got tx=%b ready=%b exp %b 0", k, tx, tx_ready, e); end
      if (k == FRAME - 1) tx_valid = 1'b0;
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
        begin errors++; $display("FAIL nothing_queued k=%0d got tx=%b busy=%b ready=%b exp 1 0 1", k, tx, tx_busy, tx_ready); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    logic       e;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    tx_valid = 1'b1; tx_data = b0;
    tick();
    tx_data = b1;
    for (int k = 0; k < FRAME; k++) begin
      e = exp_bit(b0, k, CPB, 1'b0);
      checks++;
      if (tx !== e) begin errors++; $display("FAIL b2b_first k=%0d got %b exp %b", k, tx, e); end
      tick();
    end
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_idle_gap got tx=%b busy=%b ready=%b exp 1 0 1", tx, tx_busy, tx_ready); end
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      e = exp_bit(b1, k, CPB, 1'b0);
      checks++;
      if (tx !== e || tx_done !== (k == FRAME - 1))
        begin errors++; $display("FAIL b2b_second k=%0d got tx=%b done=%b exp %b %b", k, tx, tx_done, e, (k == FRAME - 1)); end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known_bytes();
    test_random_frames();
`ifdef UART_TX_HOLD_BUF_EN
    test_hold_buffer();
`else
    test_ignore_midframe();
    test_back_to_back();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
